// File: rtl/verinject_injection_sequencer.sv
// Schedule-driven source for the verinject fault-target bus: buffers (cycle, index)
// pairs and replays each index onto the bus for one cycle when its run cycle is reached.
module verinject_injection_sequencer #(
  parameter int          SCHED_DEPTH      = 8,
  parameter int          SCHED_DEPTH_LOG2 = 3,
  parameter int          CYCLE_WIDTH      = 32,
  parameter logic [31:0] IDLE_VALUE       = 32'hFFFF_FFFF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [CYCLE_WIDTH-1:0]      cfg_cycle,
  input  logic [31:0]                 cfg_index,
  input  logic                        start,
  input  logic                        abort,
  output logic [31:0]                 verinject__injector_state,
  output logic                        busy,
  output logic                        done,
  output logic                        order_error,
  output logic [CYCLE_WIDTH-1:0]      cycle_count,
  output logic [SCHED_DEPTH_LOG2:0]   injected_count
);

  localparam int PW = SCHED_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 state;
  logic [CYCLE_WIDTH-1:0] cyc_mem [SCHED_DEPTH];
  logic [31:0]            idx_mem [SCHED_DEPTH];
  logic [CYCLE_WIDTH-1:0] last_cycle;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;

  logic                   empty;
  logic                   full;
  logic                   last_entry;
  logic                   accept;
  logic                   in_order;
  logic                   due;
  logic [CYCLE_WIDTH-1:0] head_cycle;
  logic [31:0]            head_index;

  function automatic logic [CYCLE_WIDTH-1:0] sat_inc_cycle(input logic [CYCLE_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [PW-1:0] sat_inc_count(input logic [PW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                      (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign last_entry = ((wr_ptr - rd_ptr) == PW'(1));
  assign head_cycle = cyc_mem[rd_ptr[PW-2:0]];
  assign head_index = idx_mem[rd_ptr[PW-2:0]];
  assign cfg_ready  = (state == S_IDLE) && !full;
  assign accept     = cfg_valid && cfg_ready;
  assign in_order   = empty || (cfg_cycle >= last_cycle);
  assign due        = !empty && (head_cycle <= cycle_count);

  // Schedule storage: data only, no reset needed.
  always_ff @(posedge clock) begin
    if (accept && in_order) begin
      cyc_mem[wr_ptr[PW-2:0]] <= cfg_cycle;
      idx_mem[wr_ptr[PW-2:0]] <= cfg_index;
      last_cycle              <= cfg_cycle;
    end
  end

  // Control FSM with registered bus and status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                     <= S_IDLE;
      wr_ptr                    <= '0;
      rd_ptr                    <= '0;
      order_error               <= 1'b0;
      busy                      <= 1'b0;
      done                      <= 1'b0;
      cycle_count               <= '0;
      injected_count            <= '0;
      verinject__injector_state <= IDLE_VALUE;
    end else begin
      verinject__injector_state <= IDLE_VALUE;
      if (abort) begin
        state       <= S_IDLE;
        busy        <= 1'b0;
        done        <= 1'b0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        order_error <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              if (in_order) wr_ptr <= wr_ptr + 1'b1;
              else          order_error <= 1'b1;
            end
            if (start) begin
              state          <= S_RUN;
              busy           <= 1'b1;
              cycle_count    <= '0;
              injected_count <= '0;
            end
          end
          S_RUN: begin
            cycle_count <= sat_inc_cycle(cycle_count);
            if (empty) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (due) begin
              verinject__injector_state <= head_index;
              rd_ptr <= rd_ptr + 1'b1;
              if (head_index != IDLE_VALUE) injected_count <= sat_inc_count(injected_count);
              if (last_entry) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_verinject_injection_sequencer.sv
// Directed bench for verinject_injection_sequencer: scheduled firing, ordering, full FIFO,
// abort and asynchronous reset behaviour against hand-computed expectations.
module tb_verinject_injection_sequencer;

  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_cycle = '0;
  logic [31:0] cfg_index = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] inj_state;
  logic        busy;
  logic        done;
  logic        order_error;
  logic [31:0] cycle_count;
  logic [3:0]  injected_count;

  int checks = 0;
  int failures = 0;

  verinject_injection_sequencer dut (
    .clock                     (clock),
    .reset                     (reset),
    .cfg_valid                 (cfg_valid),
    .cfg_ready                 (cfg_ready),
    .cfg_cycle                 (cfg_cycle),
    .cfg_index                 (cfg_index),
    .start                     (start),
    .abort                     (abort),
    .verinject__injector_state (inj_state),
    .busy                      (busy),
    .done                      (done),
    .order_error               (order_error),
    .cycle_count               (cycle_count),
    .injected_count            (injected_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [31:0] c, input logic [31:0] idx);
    cfg_valid = 1'b1;
    cfg_cycle = c;
    cfg_index = idx;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_bus;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_bus", inj_state, IDLE);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_oe", order_error, 0);
    chk("rst_cc", cycle_count, 0);
    chk("rst_ic", injected_count, 0);

    // (3,100), (5,7): 100 while cc=4, 7 while cc=6, done with cc=6
    load(3, 100);
    load(5, 7);
    pulse_start();
    chk("t1_busy", busy, 1);
    chk("t1_cc0", cycle_count, 0);
    chk("t1_ready_run", cfg_ready, 0);
    for (int i = 1; i <= 6; i++) begin
      step();
      exp_bus = (i == 4) ? 32'd100 : (i == 6) ? 32'd7 : IDLE;
      chk($sformatf("t1_cc_%0d", i), cycle_count, i);
      chk($sformatf("t1_bus_%0d", i), inj_state, exp_bus);
      chk($sformatf("t1_done_%0d", i), done, (i == 6) ? 1 : 0);
    end
    chk("t1_ic", injected_count, 2);
    chk("t1_busy_end", busy, 0);
    step();
    chk("t1_bus_after", inj_state, IDLE);
    chk("t1_cc_hold", cycle_count, 6);
    pulse_abort();
    chk("t1_abort_done", done, 0);
    chk("t1_abort_ready", cfg_ready, 1);
    chk("t1_abort_cc", cycle_count, 6);
    chk("t1_abort_ic", injected_count, 2);

    // Three entries sharing cycle 2 fire back to back at cc=3,4,5
    load(2, 10);
    load(2, 11);
    load(2, 12);
    pulse_start();
    for (int i = 1; i <= 5; i++) begin
      step();
      exp_bus = (i == 3) ? 32'd10 : (i == 4) ? 32'd11 : (i == 5) ? 32'd12 : IDLE;
      chk($sformatf("t2_bus_%0d", i), inj_state, exp_bus);
      chk($sformatf("t2_done_%0d", i), done, (i == 5) ? 1 : 0);
    end
    chk("t2_ic", injected_count, 3);
    pulse_abort();

    // Out-of-order entry is dropped and flagged
    load(5, 1);
    chk("t3_oe_before", order_error, 0);
    load(4, 2);
    chk("t3_oe", order_error, 1);
    pulse_start();
    for (int i = 1; i <= 6; i++) begin
      step();
      exp_bus = (i == 6) ? 32'd1 : IDLE;
      chk($sformatf("t3_bus_%0d", i), inj_state, exp_bus);
    end
    chk("t3_done", done, 1);
    chk("t3_ic", injected_count, 1);
    chk("t3_oe_sticky", order_error, 1);
    pulse_abort();
    chk("t3_oe_clear", order_error, 0);

    // Fill the FIFO, offer a ninth entry, then abort to flush
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t4_ready_%0d", k), cfg_ready, 1);
      load(k, k);
    end
    chk("t4_full_ready", cfg_ready, 0);
    load(9, 9);
    chk("t4_ninth_ready", cfg_ready, 0);
    chk("t4_ninth_oe", order_error, 0);
    pulse_abort();
    chk("t4_abort_ready", cfg_ready, 1);
    pulse_start();
    step();
    chk("t4_empty_done", done, 1);
    chk("t4_empty_ic", injected_count, 0);
    chk("t4_empty_bus", inj_state, IDLE);
    pulse_abort();

    // Asynchronous reset mid-run with entries pending
    load(10, 50);
    load(12, 51);
    pulse_start();
    step();
    step();
    chk("t5_cc_pre", cycle_count, 2);
    reset = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_cc", cycle_count, 0);
    chk("t5_rst_ready", cfg_ready, 1);
    chk("t5_rst_bus", inj_state, IDLE);
    step();
    reset = 1'b0;
    pulse_start();
    chk("t5_start_busy", busy, 1);
    step();
    chk("t5_done", done, 1);
    chk("t5_busy", busy, 0);
    chk("t5_ic", injected_count, 0);
    chk("t5_bus", inj_state, IDLE);
    pulse_abort();

    // Abort on the edge where a pop is due
    load(1, 33);
    pulse_start();
    step();
    chk("t6_cc1", cycle_count, 1);
    pulse_abort();
    chk("t6_bus", inj_state, IDLE);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_ready", cfg_ready, 1);
    step();
    chk("t6_bus_next", inj_state, IDLE);
    pulse_start();
    step();
    chk("t6_flushed_done", done, 1);
    chk("t6_flushed_ic", injected_count, 0);
    pulse_abort();

    // Index equal to the idle marker is popped without being counted
    load(0, IDLE);
    load(0, 5);
    pulse_start();
    step();
    chk("t7_bus1", inj_state, IDLE);
    chk("t7_ic1", injected_count, 0);
    chk("t7_busy1", busy, 1);
    step();
    chk("t7_bus2", inj_state, 5);
    chk("t7_ic2", injected_count, 1);
    chk("t7_done", done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/verinject_injection_sequencer.md
# verinject_injection_sequencer

Schedule-driven source for `verinject__injector_state`, the 32-bit fault-target bus consumed by the verinject memory and register injectors. The testbench loads (cycle, bit index) pairs through a valid/ready port. After `start`, the block counts run cycles and drives each scheduled index onto the bus for exactly one cycle. At all other times it drives the idle marker 32'hFFFF_FFFF.

## Interface
- `SCHED_DEPTH`, 8: schedule FIFO entries; must be a power of two.
- `SCHED_DEPTH_LOG2`, 3: log2 of `SCHED_DEPTH`.
- `CYCLE_WIDTH`, 32: width of the run-cycle counter and the scheduled cycle field.
- `IDLE_VALUE`, 32'hFFFF_FFFF: "no injection" bus value.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  schedule entry offered.
- `cfg_ready`  out  1  entry can be accepted.
- `cfg_cycle`  in  CYCLE_WIDTH  run cycle at which the entry fires.
- `cfg_index`  in  32  global bit index to flip.
- `start`  in  1  one-cycle pulse; begins a run from IDLE.
- `abort`  in  1  one-cycle pulse; flushes the schedule and returns to IDLE.
- `verinject__injector_state`  out  32  registered injection index.
- `busy`  out  1  state is RUN.
- `done`  out  1  state is DONE.
- `order_error`  out  1  sticky flag; an entry arrived out of cycle order.
- `cycle_count`  out  CYCLE_WIDTH  current run cycle.
- `injected_count`  out  SCHED_DEPTH_LOG2+1  non-idle indices emitted this run.

## Operation
- State machine: IDLE, RUN, DONE.
  - IDLE -> RUN on `start`.
  - RUN -> DONE on the edge that pops the last entry, or the first RUN edge if the FIFO is empty.
  - RUN -> IDLE and DONE -> IDLE on `abort`.
  - `start` outside IDLE is ignored.
- Loading:
  - `cfg_ready` = (state == IDLE) && FIFO not full.
  - An entry is accepted on an edge with `cfg_valid && cfg_ready`.
  - If the FIFO is non-empty and `cfg_cycle` < the last written cycle, the entry is accepted but not written, and `order_error` is set.
  - Equal cycles are legal.
- Run:
  - On the `start` edge, `cycle_count` <= 0 and `injected_count` <= 0.
  - Each RUN edge, `cycle_count` increments, saturating at all-ones with no wrap.
- Firing, each RUN edge:
  - If the FIFO is non-empty and head.cycle <= `cycle_count`: `verinject__injector_state` <= head.index and the head is popped.
  - Otherwise `verinject__injector_state` <= `IDLE_VALUE`.
  - At most one pop per cycle. Entries sharing a cycle, or falling behind, fire on consecutive cycles in load order.
- `injected_count` increments, saturating, on each pop whose index != `IDLE_VALUE`. An index equal to `IDLE_VALUE` is popped silently.
- `abort`:
  - Empties the FIFO, clears `order_error`, and forces `IDLE_VALUE` on the next edge.
  - Takes priority over a same-edge pop or `start`.
  - Leaves `cycle_count` and `injected_count` holding their values.
- Outside RUN, `verinject__injector_state` is always `IDLE_VALUE`.

## Timing
- Reset values: `verinject__injector_state` = `IDLE_VALUE`; `cfg_ready` = 1; `busy`, `done`, `order_error` = 0; `cycle_count` = 0; `injected_count` = 0. State IDLE, FIFO empty.
- Reset asserted mid-RUN: all of the above take effect immediately (asynchronous), and the FIFO is emptied.
- Latency: an entry with cycle C is visible on the bus during the cycle in which `cycle_count` reads C+1. It is held exactly one cycle unless the next entry is also due.
- `cfg_ready` drops in the same cycle that the FIFO becomes full, and is 0 throughout RUN and DONE.
- Full FIFO with `cfg_valid` high: no handshake, no state change.
- `busy` and `done` are registered state decodes; `done` rises on the same edge as the final pop.
- Empty FIFO at `start`: RUN lasts one cycle, then DONE, with `injected_count` = 0.

## Test plan
- Load (3, 100) and (5, 7), then pulse `start` -> the bus shows 100 only while `cycle_count`=4 and 7 only while `cycle_count`=6, idle elsewhere. `done` rises on the edge where `cycle_count` becomes 6, and `injected_count` = 2.
- Load (2, 10), (2, 11), (2, 12) -> 10, 11, 12 appear on consecutive cycles at `cycle_count` = 3, 4, 5.
- Load (5, 1) then (4, 2) -> `order_error` = 1, only entry 1 is stored, and the run emits only 1.
- Load 8 entries -> `cfg_ready` = 0 after the 8th, and a 9th `cfg_valid` is not accepted. Then `abort` -> FIFO empty and `cfg_ready` = 1.
- Assert `reset` mid-RUN with 2 entries still pending -> outputs go to reset values immediately, and a following `start` yields an immediate DONE with no injections.
- Pulse `abort` during RUN on a due-pop edge -> the bus stays `IDLE_VALUE` and the state is IDLE next cycle.
